// File: rtl/regfile_multiport_if.sv
// Write, issue and read bundle between the writeback/issue logic and the register file.
// master = pipeline side, slave = register file side.
interface regfile_multiport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int WR_PORTS   = 2,
  parameter int RD_PORTS   = 2
);
  localparam int AW = $clog2(REG_COUNT);

  logic                           wr_squash;
  logic [WR_PORTS-1:0]            wr_en;
  logic [WR_PORTS*AW-1:0]         wr_addr;
  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data;
  logic                           issue_en;
  logic [AW-1:0]                  issue_addr;
  logic [RD_PORTS*AW-1:0]         rd_addr;
  logic [RD_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [RD_PORTS-1:0]            rd_busy;
  logic                           busy_any;

  modport master (
    output wr_squash, wr_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  wr_squash, wr_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr,
    output rd_data, rd_busy, busy_any
  );
endinterface

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with optional read-during-write bypass
// and a per-register busy scoreboard for multi-cycle producers.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int WR_PORTS   = 2,
  parameter int RD_PORTS   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0,
  parameter int AW         = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  regfile_multiport_if.slave rf
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]  busy_q, busy_d;

  logic [WR_PORTS-1:0]   we_eff;
  logic [AW-1:0]         waddr [WR_PORTS];
  logic [DATA_WIDTH-1:0] wdata [WR_PORTS];
  logic                  iss_eff;

  // Writes and issues are also dropped while reset is high, so the bypass
  // cannot leak in-flight data onto rd_data during reset.
  always_comb begin
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      waddr[p]  = rf.wr_addr[p*AW +: AW];
      wdata[p]  = rf.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      we_eff[p] = rf.wr_en[p] && !rf.wr_squash && !reset &&
                  !((ZERO_REG != 0) && (waddr[p] == '0));
    end
    iss_eff = rf.issue_en && !rf.wr_squash && !reset &&
              !((ZERO_REG != 0) && (rf.issue_addr == '0));
  end

  // Ascending port order lets the highest-numbered port win a conflict;
  // issue is applied after the clears so a newer producer stays outstanding.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      if (we_eff[p]) begin
        regs_d[waddr[p]] = wdata[p];
        busy_d[waddr[p]] = 1'b0;
      end
    end
    if (iss_eff) busy_d[rf.issue_addr] = 1'b1;
    if (rf.wr_squash) busy_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [AW-1:0]         ra;
    logic [DATA_WIDTH-1:0] dv;
    logic                  bv;
    rf.rd_data = '0;
    rf.rd_busy = '0;
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      ra = rf.rd_addr[r*AW +: AW];
      dv = regs_q[ra];
      bv = busy_q[ra];
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < WR_PORTS; p++) begin
          if (we_eff[p] && (waddr[p] == ra)) begin
            dv = wdata[p];
            bv = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        dv = '0;
        bv = 1'b0;
      end
      rf.rd_data[r*DATA_WIDTH +: DATA_WIDTH] = dv;
      rf.rd_busy[r] = bv;
    end
  end

  assign rf.busy_any = |busy_q;

  a_port_counts: assert property (@(posedge clk) (WR_PORTS >= 1) && (RD_PORTS >= 1));
  a_reg_count_pow2: assert property (@(posedge clk)
    (REG_COUNT >= 2) && ((REG_COUNT & (REG_COUNT - 1)) == 0));

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: DUT A (32x32, 2W/2R, bypass) and DUT B (16x16, 3W/4R,
// no bypass, hard-wired r0) checked against a register/scoreboard reference model.
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_WIDTH(32), .REG_COUNT(32), .WR_PORTS(2), .RD_PORTS(2)) ifa ();
  regfile_multiport_if #(.DATA_WIDTH(16), .REG_COUNT(16), .WR_PORTS(3), .RD_PORTS(4)) ifb ();

  regfile_multiport #(
    .DATA_WIDTH(32), .REG_COUNT(32), .WR_PORTS(2), .RD_PORTS(2), .BYPASS(1), .ZERO_REG(0)
  ) dut_a (.clk(clk), .reset(rst), .rf(ifa));

  regfile_multiport #(
    .DATA_WIDTH(16), .REG_COUNT(16), .WR_PORTS(3), .RD_PORTS(4), .BYPASS(0), .ZERO_REG(1)
  ) dut_b (.clk(clk), .reset(rst), .rf(ifb));

  int checks = 0;
  int errors = 0;

  // Generic per-configuration stimulus (index 0 = A, 1 = B)
  logic        s_sq  [2];
  logic        s_ien [2];
  logic [4:0]  s_ia  [2];
  logic        s_wen [2][3];
  logic [4:0]  s_wa  [2][3];
  logic [31:0] s_wd  [2][3];
  logic [4:0]  s_ra  [2][4];

  // Reference model state
  logic [31:0] m_reg  [2][32];
  logic        m_busy [2][32];

  function automatic int wp(int c);  return (c == 1) ? 3 : 2;  endfunction
  function automatic int rpn(int c); return (c == 1) ? 4 : 2;  endfunction
  function automatic int rc(int c);  return (c == 1) ? 16 : 32; endfunction
  function automatic logic byp(int c); return (c == 0); endfunction
  function automatic logic zr(int c);  return (c == 1); endfunction
  function automatic string cn(int c); return (c == 1) ? "B" : "A"; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_d(int c, int r);
    if (c == 0) return ifa.rd_data[r*32 +: 32];
    return {16'h0, ifb.rd_data[r*16 +: 16]};
  endfunction

  function automatic logic act_b(int c, int r);
    if (c == 0) return ifa.rd_busy[r];
    return ifb.rd_busy[r];
  endfunction

  function automatic logic act_any(int c);
    return (c == 0) ? ifa.busy_any : ifb.busy_any;
  endfunction

  function automatic logic eff(int c, int p);
    return (p < wp(c)) && s_wen[c][p] && !s_sq[c] && !rst && !(zr(c) && s_wa[c][p] == 5'd0);
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < 2; c++) begin
      s_sq[c] = 1'b0; s_ien[c] = 1'b0; s_ia[c] = 5'd0;
      for (int p = 0; p < 3; p++) begin
        s_wen[c][p] = 1'b0; s_wa[c][p] = 5'd0; s_wd[c][p] = 32'h0;
      end
      for (int r = 0; r < 4; r++) s_ra[c][r] = 5'd0;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin
        m_reg[c][r] = 32'h0;
        m_busy[c][r] = 1'b0;
      end
  endtask

  task automatic drive();
    ifa.wr_squash  = s_sq[0];
    ifa.issue_en   = s_ien[0];
    ifa.issue_addr = s_ia[0];
    for (int p = 0; p < 2; p++) begin
      ifa.wr_en[p] = s_wen[0][p];
      ifa.wr_addr[p*5 +: 5] = s_wa[0][p];
      ifa.wr_data[p*32 +: 32] = s_wd[0][p];
      ifa.rd_addr[p*5 +: 5] = s_ra[0][p];
    end
    ifb.wr_squash  = s_sq[1];
    ifb.issue_en   = s_ien[1];
    ifb.issue_addr = s_ia[1][3:0];
    for (int p = 0; p < 3; p++) begin
      ifb.wr_en[p] = s_wen[1][p];
      ifb.wr_addr[p*4 +: 4] = s_wa[1][p][3:0];
      ifb.wr_data[p*16 +: 16] = s_wd[1][p][15:0];
    end
    for (int r = 0; r < 4; r++) ifb.rd_addr[r*4 +: 4] = s_ra[1][r][3:0];
  endtask

  // What a reader should see this cycle: stored value, or with bypass the
  // latest-port effective write to that address.
  task automatic exp_read(input int c, input logic [4:0] ra,
                          output logic [31:0] d, output logic b);
    d = m_reg[c][ra];
    b = m_busy[c][ra];
    if (byp(c)) begin
      for (int p = wp(c) - 1; p >= 0; p--) begin
        if (eff(c, p) && s_wa[c][p] == ra) begin
          d = s_wd[c][p];
          b = 1'b0;
          break;
        end
      end
    end
    if (zr(c) && ra == 5'd0) begin
      d = 32'h0;
      b = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < rc(c); r++) begin
        int   win;
        logic nb;
        win = -1;
        for (int p = 0; p < wp(c); p++)
          if (eff(c, p) && s_wa[c][p] == 5'(r)) win = p;
        nb = m_busy[c][r];
        if (s_sq[c]) nb = 1'b0;
        else if (s_ien[c] && s_ia[c] == 5'(r) && !(zr(c) && r == 0)) nb = 1'b1;
        else if (win >= 0) nb = 1'b0;
        if (win >= 0) m_reg[c][r] = s_wd[c][win];
        m_busy[c][r] = nb;
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] ed;
    logic        eb, ea;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < rpn(c); r++) begin
        exp_read(c, s_ra[c][r], ed, eb);
        chk($sformatf("%s rd%0d data @%0t", cn(c), r, $time), act_d(c, r), ed);
        chk($sformatf("%s rd%0d busy @%0t", cn(c), r, $time), {31'b0, act_b(c, r)}, {31'b0, eb});
      end
      ea = 1'b0;
      for (int r = 0; r < rc(c); r++) ea = ea | m_busy[c][r];
      chk($sformatf("%s busy_any @%0t", cn(c), $time), {31'b0, act_any(c)}, {31'b0, ea});
    end
  endtask

  task automatic apply_and_check();
    drive();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  function automatic logic [4:0] pick_addr(int c);
    int amax;
    amax = (c == 1) ? 15 : 31;
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, amax));
    return 5'($urandom_range(0, 3));
  endfunction

  task automatic rand_stim(input int c);
    s_sq[c]  = ($urandom_range(0, 15) == 0);
    s_ien[c] = ($urandom_range(0, 2) == 0);
    s_ia[c]  = pick_addr(c);
    for (int p = 0; p < 3; p++) begin
      s_wen[c][p] = (p < wp(c)) && ($urandom_range(0, 1) == 1);
      s_wa[c][p]  = pick_addr(c);
      s_wd[c][p]  = (c == 1) ? {16'h0, 16'($urandom)} : 32'($urandom);
    end
    for (int r = 0; r < 4; r++) s_ra[c][r] = pick_addr(c);
  endtask

  typedef struct {
    logic        sq;
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        ie;  logic [4:0] ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic        eb0, eb1, eany;
  } vec_t;

  vec_t tv [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Expected outputs of DUT A, cycle by cycle
    tv[ 0] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd5,5'd5, 32'h0,32'h0,               1'b0,1'b0,1'b0};
    tv[ 1] = '{1'b0, 1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd5,5'd5, 32'hDEADBEEF,32'hDEADBEEF, 1'b0,1'b0,1'b0};
    tv[ 2] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd5,5'd5, 32'hDEADBEEF,32'hDEADBEEF, 1'b0,1'b0,1'b0};
    tv[ 3] = '{1'b0, 1'b1,5'd7,32'h11111111, 1'b1,5'd7,32'h22222222, 1'b0,5'd0, 5'd7,5'd5, 32'h22222222,32'hDEADBEEF, 1'b0,1'b0,1'b0};
    tv[ 4] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7,5'd7, 32'h22222222,32'h22222222, 1'b0,1'b0,1'b0};
    tv[ 5] = '{1'b0, 1'b1,5'd3,32'h1357,     1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd3,5'd4, 32'h1357,32'h0,            1'b0,1'b0,1'b0};
    tv[ 6] = '{1'b1, 1'b1,5'd3,32'hAAAA,     1'b0,5'd0,32'h0,        1'b1,5'd4, 5'd3,5'd4, 32'h1357,32'h0,            1'b0,1'b0,1'b0};
    tv[ 7] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd3,5'd4, 32'h1357,32'h0,            1'b0,1'b0,1'b0};
    tv[ 8] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd9, 5'd9,5'd9, 32'h0,32'h0,               1'b0,1'b0,1'b0};
    tv[ 9] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd0, 32'h0,32'h0,               1'b1,1'b0,1'b1};
    tv[10] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd9, 32'h0,32'h0,               1'b1,1'b1,1'b1};
    tv[11] = '{1'b0, 1'b1,5'd9,32'h55,       1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd9, 32'h55,32'h55,             1'b0,1'b0,1'b1};
    tv[12] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd9, 32'h55,32'h55,             1'b0,1'b0,1'b0};
    tv[13] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd9, 5'd9,5'd9, 32'h55,32'h55,             1'b0,1'b0,1'b0};
    tv[14] = '{1'b0, 1'b0,5'd0,32'h0,        1'b1,5'd9,32'h66,       1'b1,5'd9, 5'd9,5'd9, 32'h66,32'h66,             1'b0,1'b0,1'b1};
    tv[15] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd9, 32'h66,32'h66,             1'b1,1'b1,1'b1};
    tv[16] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd9, 32'h66,32'h66,             1'b1,1'b1,1'b1};
    tv[17] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd9, 32'h66,32'h66,             1'b0,1'b0,1'b0};

    model_reset();
    clear_stim();

    // Reset with a write pending: outputs stay 0
    s_wen[0][0] = 1'b1; s_wa[0][0] = 5'd5; s_wd[0][0] = 32'hDEADBEEF;
    s_ra[0][0] = 5'd5; s_ra[0][1] = 5'd5;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset A rd0 data", act_d(0, 0), 32'h0);
    chk("reset A rd1 data", act_d(0, 1), 32'h0);
    chk("reset B rd0 data", act_d(1, 0), 32'h0);
    chk("reset A busy_any", {31'b0, act_any(0)}, 32'h0);
    check_model();
    rst = 1'b0;
    clear_stim();
    drive();
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      clear_stim();
      s_sq[0] = tv[i].sq; s_ien[0] = tv[i].ie; s_ia[0] = tv[i].ia;
      s_wen[0][0] = tv[i].we0; s_wa[0][0] = tv[i].wa0; s_wd[0][0] = tv[i].wd0;
      s_wen[0][1] = tv[i].we1; s_wa[0][1] = tv[i].wa1; s_wd[0][1] = tv[i].wd1;
      s_ra[0][0] = tv[i].ra0; s_ra[0][1] = tv[i].ra1;
      apply_and_check();
      chk($sformatf("T%0d rd0 data", i), act_d(0, 0), tv[i].ed0);
      chk($sformatf("T%0d rd1 data", i), act_d(0, 1), tv[i].ed1);
      chk($sformatf("T%0d rd0 busy", i), {31'b0, act_b(0, 0)}, {31'b0, tv[i].eb0});
      chk($sformatf("T%0d rd1 busy", i), {31'b0, act_b(0, 1)}, {31'b0, tv[i].eb1});
      chk($sformatf("T%0d busy_any", i), {31'b0, act_any(0)}, {31'b0, tv[i].eany});
      advance();
    end

    // B: hard-wired r0 ignores write and issue
    clear_stim();
    s_wen[1][2] = 1'b1; s_wa[1][2] = 5'd0; s_wd[1][2] = 32'hFFFF;
    s_ien[1] = 1'b1; s_ia[1] = 5'd0;
    apply_and_check();
    chk("B r0 data write cycle", act_d(1, 0), 32'h0);
    advance();
    clear_stim();
    apply_and_check();
    chk("B r0 data after", act_d(1, 0), 32'h0);
    chk("B r0 busy after", {31'b0, act_b(1, 0)}, 32'h0);
    chk("B busy_any after r0 issue", {31'b0, act_any(1)}, 32'h0);
    advance();

    // B: three-port conflict, no bypass
    clear_stim();
    for (int p = 0; p < 3; p++) begin
      s_wen[1][p] = 1'b1; s_wa[1][p] = 5'd7; s_wd[1][p] = 32'h1111 * (p + 1);
    end
    s_ra[1][0] = 5'd7;
    apply_and_check();
    chk("B r7 conflict same cycle", act_d(1, 0), 32'h0);
    advance();
    clear_stim();
    s_ra[1][0] = 5'd7;
    apply_and_check();
    chk("B r7 conflict winner", act_d(1, 0), 32'h3333);
    advance();

    // B: scoreboard without same-cycle override
    clear_stim();
    s_ien[1] = 1'b1; s_ia[1] = 5'd9; s_ra[1][0] = 5'd9;
    apply_and_check();
    chk("B r9 busy issue cycle", {31'b0, act_b(1, 0)}, 32'h0);
    advance();
    for (int k = 0; k < 2; k++) begin
      clear_stim();
      s_ra[1][0] = 5'd9;
      apply_and_check();
      chk("B r9 busy pending", {31'b0, act_b(1, 0)}, 32'h1);
      advance();
    end
    clear_stim();
    s_wen[1][1] = 1'b1; s_wa[1][1] = 5'd9; s_wd[1][1] = 32'h55; s_ra[1][0] = 5'd9;
    apply_and_check();
    chk("B r9 busy write cycle", {31'b0, act_b(1, 0)}, 32'h1);
    chk("B r9 data write cycle", act_d(1, 0), 32'h0);
    advance();
    clear_stim();
    s_ra[1][0] = 5'd9;
    apply_and_check();
    chk("B r9 busy after write", {31'b0, act_b(1, 0)}, 32'h0);
    chk("B r9 data after write", act_d(1, 0), 32'h55);
    advance();
    clear_stim();
    s_wen[1][0] = 1'b1; s_wa[1][0] = 5'd9; s_wd[1][0] = 32'h77;
    s_ien[1] = 1'b1; s_ia[1] = 5'd9; s_ra[1][0] = 5'd9;
    apply_and_check();
    advance();
    clear_stim();
    s_ra[1][0] = 5'd9;
    apply_and_check();
    chk("B r9 set wins over clear", {31'b0, act_b(1, 0)}, 32'h1);
    chk("B r9 data rewritten", act_d(1, 0), 32'h77);
    advance();
    clear_stim();
    s_sq[1] = 1'b1;
    apply_and_check();
    advance();
    clear_stim();
    apply_and_check();
    chk("B busy_any after squash", {31'b0, act_any(1)}, 32'h0);
    advance();

    // Mid-cycle asynchronous reset with writes and issues in flight
    clear_stim();
    for (int c = 0; c < 2; c++) begin
      s_wen[c][0] = 1'b1; s_wa[c][0] = 5'd2; s_wd[c][0] = 32'h4321;
      s_ien[c] = 1'b1; s_ia[c] = 5'd3;
    end
    apply_and_check();
    advance();
    clear_stim();
    for (int c = 0; c < 2; c++) begin
      s_wen[c][0] = 1'b1; s_wa[c][0] = 5'd2; s_wd[c][0] = 32'h1234;
      s_ien[c] = 1'b1; s_ia[c] = 5'd2;
      s_ra[c][0] = 5'd2; s_ra[c][1] = 5'd3;
    end
    drive();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst A r2 data", act_d(0, 0), 32'h0);
    chk("midrst A r3 busy", {31'b0, act_b(0, 1)}, 32'h0);
    chk("midrst A busy_any", {31'b0, act_any(0)}, 32'h0);
    chk("midrst B r2 data", act_d(1, 0), 32'h0);
    chk("midrst B busy_any", {31'b0, act_any(1)}, 32'h0);
    check_model();
    @(posedge clk);
    #3;
    rst = 1'b0;
    clear_stim();
    for (int c = 0; c < 2; c++) begin
      s_ra[c][0] = 5'd2; s_ra[c][1] = 5'd3;
    end
    drive();
    advance();
    apply_and_check();
    chk("post-rst A r2 data", act_d(0, 0), 32'h0);
    chk("post-rst B r2 data", act_d(1, 0), 32'h0);
    advance();

    // Randomised traffic on both configurations
    for (int i = 0; i < 600; i++) begin
      rand_stim(0);
      rand_stim(1);
      apply_and_check();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the two-write/two-read CPU register file.
- Configurable data width, register count, write-port count and read-port count.
- Adds optional read-during-write bypass and a per-register busy scoreboard for multi-cycle producers (loads, multiply/divide high words).
- Sits between the writeback muxes and the operand fetch stage.
- `wr_squash` takes over the role of the existing exception-pending write gating.

Parameters:
- DATA_WIDTH, 32, width of each register in bits.
- REG_COUNT, 32, number of registers; must be a power of two, >= 2.
- WR_PORTS, 2, number of write ports.
- RD_PORTS, 2, number of read ports.
- BYPASS, 1, 1 = read data reflects same-cycle writes; 0 = read data shows the pre-write contents.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and issues.
- AW, $clog2(REG_COUNT), address width (derived; do not override).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_squash  in  1  suppresses all writes and issues this cycle, and clears the scoreboard.
- wr_en  in  WR_PORTS  per-port write enable.
- wr_addr  in  WR_PORTS*AW  packed write addresses; port p is at [p*AW +: AW].
- wr_data  in  WR_PORTS*DATA_WIDTH  packed write data.
- issue_en  in  1  marks issue_addr busy (a result is outstanding).
- issue_addr  in  AW  register that will be written later.
- rd_addr  in  RD_PORTS*AW  packed read addresses.
- rd_data  out  RD_PORTS*DATA_WIDTH  packed read data (combinational).
- rd_busy  out  RD_PORTS  per-port: the addressed register is still awaiting its producer.
- busy_any  out  1  OR of all scoreboard bits.

Behaviour:
- **Reset (asynchronous):**
  - All registers become 0 and all busy bits become 0.
  - Outputs: rd_data = 0 for every port; rd_busy = 0; busy_any = 0.
- **Writes:**
  - A write on port p is effective when wr_en[p] && !wr_squash.
  - Effective writes take place at the next rising edge; write latency is 1 cycle.
- **Write conflicts:**
  - When several effective writes target the same address, the highest-numbered port wins.
  - Writes to distinct addresses all take place in the same cycle.
- **Reads:**
  - Combinational from rd_addr; there is no read-port conflict limit.
  - BYPASS=1: if an effective write targets rd_addr this cycle, rd_data shows that write's data (highest winning port); otherwise it shows the stored value.
  - BYPASS=0: rd_data always shows the stored value; new data is visible in the cycle after the write.
- **ZERO_REG=1:**
  - Address 0 reads 0, ignores writes, ignores issue, and always reports rd_busy = 0.
  - The bypass never forwards to address 0.
- **Scoreboard, one busy bit per register:**
  - Set: issue_en && !wr_squash sets busy[issue_addr] at the next edge.
  - Clear: an effective write to register r clears busy[r] at the next edge.
  - Same-cycle set and clear on the same register: set wins, because the newer producer is outstanding.
  - wr_squash: clears every busy bit at the next edge and overrides any issue in the same cycle.
- **rd_busy[p]:**
  - Equals busy[rd_addr[p]].
  - BYPASS=1: forced to 0 when an effective write targets rd_addr[p] this cycle.
  - BYPASS=0: no same-cycle override.
- **busy_any:** OR-reduction of the registered busy bits (no bypass term).
- **Reset during operation:** any in-flight write or issue in the reset cycle is discarded; contents return to 0.
- **Address range:** no out-of-range addresses exist, since REG_COUNT is a power of two.
- **Implementation:**
  - Storage is a flop array; there is no RAM inference requirement.
  - Write-port count must not restrict synthesis.
- **Assertions (simulation only):**
  - WR_PORTS >= 1 and RD_PORTS >= 1.
  - REG_COUNT is a power of two.

Test Plan:
1. **Reset and basic write/read.** Apply reset; write r5=0xDEADBEEF on port 0, then read r5 on both read ports.
   -> rd_data = 0 during reset; 0xDEADBEEF in the cycle after the write.
   -> With BYPASS=1, 0xDEADBEEF also appears in the write cycle.
2. **Write conflict.** Ports 0 and 1 both write r7 (0x11111111 and 0x22222222) in the same cycle.
   -> r7 = 0x22222222.
   -> With BYPASS=1, rd_data shows 0x22222222 in that same cycle.
3. **Squash.** wr_squash=1 with a port-0 write r3=0xAAAA and issue_en to r4.
   -> r3 keeps its old value; busy[r4] = 0; busy_any = 0 next cycle.
4. **Scoreboard sequence.** Issue r9 -> rd_busy=1 on a port reading r9. Three cycles later, write r9=0x55 -> rd_busy=0 in the write cycle (BYPASS=1) or the next cycle (BYPASS=0).
   - Same-cycle write and re-issue of r9 -> busy stays 1.
5. **ZERO_REG=1.** Write r0=0xFFFFFFFF and issue r0.
   -> rd_data = 0; rd_busy = 0; busy_any unaffected.
6. **Mid-operation reset.** Issue r2 and write r2=0x1234, asserting reset asynchronously mid-cycle.
   -> r2 = 0 and busy = 0 immediately.
   - Repeat with DATA_WIDTH=16, REG_COUNT=16, WR_PORTS=3, RD_PORTS=4.
